hrm_fetch_seq: RTL and testbench
================================

Name: hrm_fetch_seq

Overview:
- Instruction fetch/sequencer for the HRM CPU. It is the producing end of the opcode interface: it reads 8-bit words from program memory, holds the instruction and optional operand, and presents `opcode` to the control unit.
- It consumes the control unit's `branch`, `ijump`, `rIn` and `wO` strobes to resolve jumps and to stall on inbox/outbox handshakes.
- It issues a one-cycle `exec` strobe that qualifies all datapath write enables.

Parameters:
- PC_W, 8, program counter / program memory address width.
- OPERAND_MASK, 16'hFFFF, bit i set means opcode i carries a second (operand) byte.
- HALT_OPCODE, 4'hF, opcode that stops sequencing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pm_addr  out  PC_W  program memory address; always equals PC.
- pm_data  in  8  program memory read data; registered ROM, valid one cycle after pm_addr is stable.
- opcode  out  4  IR[7:4], to the control unit.
- cond  out  2  IR[1:0]: branch condition (00 always, 01 zero, 10 negative, 11 never).
- operand  out  8  operand register, to datapath and memory address mux.
- branch  in  1  from control unit: conditional jump instruction.
- ijump  in  1  from control unit: unconditional jump instruction.
- rIn  in  1  from control unit: instruction reads inbox.
- wO  in  1  from control unit: instruction writes outbox.
- alu_zero  in  1  accumulator == 0.
- alu_neg  in  1  accumulator sign bit.
- in_valid  in  1  inbox has data.
- out_ready  in  1  outbox can accept data.
- exec  out  1  one-cycle execute strobe; datapath gates wR/wM/rIn/wO with it.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (async, rst_n low): state = FETCH, PC = 0, IR = 0, operand = 0, exec = 0, halted = 0. Reset asserted mid-instruction aborts it; no exec pulse is produced.
- States: FETCH, DECODE, OPWAIT, OPLOAD, EXECUTE, HALT. `exec`/`halted` are registered from next-state.
- FETCH: PC stable for one cycle -> DECODE.
- DECODE: IR <= pm_data; PC <= PC+1.
  - If pm_data[7:4] == HALT_OPCODE -> HALT.
  - Else if OPERAND_MASK[pm_data[7:4]] -> OPWAIT.
  - Else -> EXECUTE.
- OPWAIT: wait one cycle (ROM latency) -> OPLOAD.
- OPLOAD: operand <= pm_data; PC <= PC+1 -> EXECUTE.
- EXECUTE, stall conditions: stay in EXECUTE with exec = 0 while (rIn && !in_valid) or (wO && !out_ready).
- EXECUTE, otherwise: exec = 1 for exactly this cycle, then -> FETCH, with the next PC chosen as follows:
  - ijump: PC <= operand.
  - branch and condition true: PC <= operand.
    - cond 00 true.
    - 01 true when alu_zero.
    - 10 true when alu_neg.
    - 11 false.
  - Otherwise PC unchanged (already advanced).
  - ijump takes priority if both ijump and branch are asserted.
- The branch condition samples alu_zero/alu_neg in the EXECUTE cycle. These are the flags before this instruction's own write.
- HALT: halted = 1; PC, IR and operand frozen; exec = 0; exit only via reset.
- PC arithmetic is modulo 2^PC_W: PC 255 +1 -> 0, in both DECODE and OPLOAD. An operand byte at address 255 is fetched from address 0.
- Latency: 1-byte instruction 3 cycles, 2-byte instruction 5 cycles, each plus stall cycles.
- opcode, cond and operand are stable from the cycle after DECODE/OPLOAD through EXECUTE.

Decomposition:
- Shared package `hrm_pkg`: opcode constants (including HALT), cond encodings, state enum, PC_W default.
- One natural sub-module: `hrm_pc` (PC register with load/increment/hold and wraparound).
- The FSM stays in hrm_fetch_seq.

Test Plan:
- Straight line: PM = {0x10, 0x20, 0xF0}, mask excludes 1, 2 -> exec pulses at cycles 3 and 6; opcode 1 then 2; halted = 1 at cycle 8; PC frozen at 3.
- Two-byte jump: PM[0] = 0x80 (ijump, operand), PM[1] = 0x05, PM[5] = 0xF0 -> operand = 5; exec at cycle 5; next pm_addr = 5; then halted.
- Conditional branches with cond 01:
  - alu_zero = 1 -> PC loads operand.
  - Rerun with alu_zero = 0 -> PC = 2.
  - cond 11 never branches.
- Inbox stall: rIn = 1 with in_valid low for 4 cycles -> exec = 0 for 4 cycles, then a single exec pulse in the cycle in_valid rises. Same check for wO/out_ready.
- Wrap: start PC at 254 via program padding; 2-byte instruction at 255 -> operand read from address 0; PC = 1 after OPLOAD.
- Async reset: assert rst_n low during OPWAIT -> outputs reset immediately (no clock edge); PC = 0; no exec; normal fetch from address 0 after release.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM instruction fetch/sequencer: opcode and
// branch-condition encodings, the sequencer state enum and PC controls.
package hrm_pkg;

    localparam int PC_W_DEF = 8;

    // Opcode that stops sequencing until reset.
    localparam logic [3:0] OP_HALT = 4'hF;

    // Branch condition field, IR[1:0].
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_NEG    = 2'b10;
    localparam logic [1:0] COND_NEVER  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_OPWAIT  = 3'd2,
        ST_OPLOAD  = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // What the PC register does on the next clock edge.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_op_t;

    // Evaluate a branch condition against the accumulator flags.
    function automatic logic cond_true(input logic [1:0] cond,
                                       input logic       zero,
                                       input logic       neg);
        logic result;
        case (cond)
            COND_ALWAYS: result = 1'b1;
            COND_ZERO:   result = zero;
            COND_NEG:    result = neg;
            COND_NEVER:  result = 1'b0;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hrm_fetch_seq_if.sv
// Bundle of the program-memory bus and control-unit handshake seen by the
// fetch sequencer. The sequencer is the master; memory, control unit and
// datapath together form the slave side.
interface hrm_fetch_seq_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pm_addr;
    logic [7:0]      pm_data;
    logic [3:0]      opcode;
    logic [1:0]      cond;
    logic [7:0]      operand;
    logic            branch;
    logic            ijump;
    logic            rIn;
    logic            wO;
    logic            alu_zero;
    logic            alu_neg;
    logic            in_valid;
    logic            out_ready;
    logic            exec;
    logic            halted;

    modport master (
        output pm_addr, opcode, cond, operand, exec, halted,
        input  pm_data, branch, ijump, rIn, wO,
               alu_zero, alu_neg, in_valid, out_ready
    );

    modport slave (
        input  pm_addr, opcode, cond, operand, exec, halted,
        output pm_data, branch, ijump, rIn, wO,
               alu_zero, alu_neg, in_valid, out_ready
    );
endinterface

// File: rtl/hrm_pc.sv
// Program counter: hold, increment (wrapping modulo 2^PC_W) or load.
module hrm_pc
    import hrm_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_op_t          op,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_reg;

    // PC update; the natural overflow of the adder gives the wraparound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else begin
            case (op)
                PC_INC:  pc_reg <= pc_reg + PC_W'(1);
                PC_LOAD: pc_reg <= load_val;
                default: pc_reg <= pc_reg;
            endcase
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/hrm_fetch_seq.sv
// HRM instruction fetch/sequencer. Walks FETCH -> DECODE -> [OPWAIT ->
// OPLOAD] -> EXECUTE, holding IR and operand for the control unit, stalling
// on inbox/outbox handshakes and resolving jumps at the end of EXECUTE.
// exec is registered from the EXECUTE exit, so its one-cycle pulse lands in
// the following FETCH cycle; IR and operand are untouched until the next
// DECODE, so the control unit's strobes still describe the retiring
// instruction while datapath writes are enabled.
module hrm_fetch_seq
    import hrm_pkg::*;
#(
    parameter int         PC_W         = PC_W_DEF,
    parameter logic [15:0] OPERAND_MASK = 16'hFFFF,
    parameter logic [3:0]  HALT_OPCODE  = OP_HALT
) (
    input logic            clk,
    input logic            rst_n,
    hrm_fetch_seq_if.master bus
);

    state_t          state_reg;
    logic [3:0]      opc_reg;
    logic [1:0]      cond_reg;
    logic [7:0]      operand_reg;
    logic            exec_reg;
    logic            halted_reg;

    logic [PC_W-1:0] pc;
    pc_op_t          pc_op;
    logic            stall;
    logic            take_jump;
    logic [3:0]      fetched_opc;

    assign fetched_opc = bus.pm_data[7:4];

    // An instruction waits in EXECUTE while its I/O partner is not ready.
    assign stall = (bus.rIn && !bus.in_valid) || (bus.wO && !bus.out_ready);

    // ijump wins over branch; the flags are those present before this
    // instruction's own write, since that write happens under exec later.
    assign take_jump = bus.ijump ||
                       (bus.branch && cond_true(cond_reg, bus.alu_zero, bus.alu_neg));

    // PC control: step past each byte consumed, load the operand on a jump.
    always_comb begin
        pc_op = PC_HOLD;
        case (state_reg)
            ST_DECODE:  pc_op = PC_INC;
            ST_OPLOAD:  pc_op = PC_INC;
            ST_EXECUTE: if (!stall && take_jump) pc_op = PC_LOAD;
            default:    pc_op = PC_HOLD;
        endcase
    end

    hrm_pc #(
        .PC_W(PC_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (pc_op),
        .load_val (PC_W'(operand_reg)),
        .pc       (pc)
    );

    // Sequencer FSM with instruction/operand registers and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_FETCH;
            opc_reg     <= '0;
            cond_reg    <= '0;
            operand_reg <= '0;
            exec_reg    <= 1'b0;
            halted_reg  <= 1'b0;
        end else begin
            exec_reg <= 1'b0;
            case (state_reg)
                ST_FETCH: begin
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    opc_reg  <= fetched_opc;
                    cond_reg <= bus.pm_data[1:0];
                    if (fetched_opc == HALT_OPCODE) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else if (OPERAND_MASK[fetched_opc]) begin
                        state_reg <= ST_OPWAIT;
                    end else begin
                        state_reg <= ST_EXECUTE;
                    end
                end
                ST_OPWAIT: begin
                    state_reg <= ST_OPLOAD;
                end
                ST_OPLOAD: begin
                    operand_reg <= bus.pm_data;
                    state_reg   <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (!stall) begin
                        exec_reg  <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.pm_addr = pc;
    assign bus.opcode  = opc_reg;
    assign bus.cond    = cond_reg;
    assign bus.operand = operand_reg;
    assign bus.exec    = exec_reg;
    assign bus.halted  = halted_reg;

endmodule

// File: tb/tb_hrm_fetch_seq.sv
// Testbench for hrm_fetch_seq: table of single-instruction programs,
// directed multi-cycle sequences (straight line, stalls, wrap, async reset)
// and random programs checked against an instruction-level model.
module tb_hrm_fetch_seq;
    import hrm_pkg::*;

    // Opcodes 8..B carry an operand byte. Control-unit decode used here:
    // 8 ijump, 9 branch, A both ijump and branch, 4 reads inbox, 5 writes outbox.
    localparam logic [15:0] MASK = 16'h0F00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hrm_fetch_seq_if #(.PC_W(8)) bus ();

    hrm_fetch_seq #(
        .PC_W         (8),
        .OPERAND_MASK (MASK),
        .HALT_OPCODE  (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered program ROM.
    logic [7:0] pm [256];
    always @(posedge clk) bus.pm_data <= pm[bus.pm_addr];

    // Control unit decode.
    assign bus.ijump  = (bus.opcode == 4'h8) || (bus.opcode == 4'hA);
    assign bus.branch = (bus.opcode == 4'h9) || (bus.opcode == 4'hA);
    assign bus.rIn    = (bus.opcode == 4'h4);
    assign bus.wO     = (bus.opcode == 4'h5);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic fill_pm(input logic [7:0] val);
        for (int i = 0; i < 256; i++) pm[i] = val;
    endtask

    task automatic wait_exec(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.exec) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_halt(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.halted) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Stall test: the handshake input stays low for stall_len EXECUTE cycles.
    task automatic stall_test(input string name, input logic [7:0] instr,
                              input bit use_in, input int stall_len);
        int exec_cnt;
        int exec_at;
        fill_pm(8'hF0);
        pm[0] = instr;
        bus.in_valid  = use_in ? 1'b0 : 1'b1;
        bus.out_ready = use_in ? 1'b1 : 1'b0;
        do_reset();
        exec_cnt = 0;
        exec_at  = -1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.exec) begin
                exec_cnt++;
                exec_at = cyc;
            end
            if (cyc >= 2 + stall_len) begin
                bus.in_valid  = 1'b1;
                bus.out_ready = 1'b1;
            end
        end
        $display("%s: stall %0d, exec pulses %0d, last at cycle %0d", name, stall_len, exec_cnt, exec_at);
        check({name, "_exec_count"}, exec_cnt, 1);
        check({name, "_exec_cycle"}, exec_at, 3 + stall_len);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic       z;
        logic       n;
        int         exp_cyc;
        logic [7:0] exp_pc;
        logic [3:0] exp_op;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int  at;
        bit  ok;
        int  q_cyc [$];
        int  q_op  [$];
        int  halt_at;
        int  n_exec;
        int  prev;
        logic [7:0] pc_m, b_m, opnd_m, next_m;
        logic [3:0] op_m;
        int  len_m;
        bit  taken_m;
        bit  zero_m, neg_m;

        bus.alu_zero  = 1'b0;
        bus.alu_neg   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        fill_pm(8'hF0);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        #3;
        check("reset_pm_addr", bus.pm_addr, 0);
        check("reset_exec",    bus.exec,    0);
        check("reset_halted",  bus.halted,  0);
        check("reset_opcode",  bus.opcode,  0);
        check("reset_operand", bus.operand, 0);

        // ---------------- table of single instructions ----------------
        tbl[0]  = '{8'h10, 8'hF0, 1'b0, 1'b0, 3, 8'h01, 4'h1};
        tbl[1]  = '{8'h80, 8'h05, 1'b0, 1'b0, 5, 8'h05, 4'h8};
        tbl[2]  = '{8'h91, 8'h07, 1'b1, 1'b0, 5, 8'h07, 4'h9};
        tbl[3]  = '{8'h91, 8'h07, 1'b0, 1'b0, 5, 8'h02, 4'h9};
        tbl[4]  = '{8'h93, 8'h07, 1'b1, 1'b1, 5, 8'h02, 4'h9};
        tbl[5]  = '{8'h90, 8'h09, 1'b0, 1'b0, 5, 8'h09, 4'h9};
        tbl[6]  = '{8'h92, 8'h09, 1'b0, 1'b1, 5, 8'h09, 4'h9};
        tbl[7]  = '{8'h92, 8'h09, 1'b1, 1'b0, 5, 8'h02, 4'h9};
        tbl[8]  = '{8'hA3, 8'h0C, 1'b0, 1'b0, 5, 8'h0C, 4'hA};
        tbl[9]  = '{8'h40, 8'hF0, 1'b0, 1'b0, 3, 8'h01, 4'h4};
        tbl[10] = '{8'h50, 8'hF0, 1'b0, 1'b0, 3, 8'h01, 4'h5};

        for (int v = 0; v < 11; v++) begin
            fill_pm(8'hF0);
            pm[0] = tbl[v].b0;
            pm[1] = tbl[v].b1;
            bus.alu_zero  = tbl[v].z;
            bus.alu_neg   = tbl[v].n;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            do_reset();
            wait_exec(20, at, ok);
            $display("vec %0d: instr %02h %02h -> exec at %0d, pm_addr %0d, opcode %0h",
                     v, tbl[v].b0, tbl[v].b1, at, bus.pm_addr, bus.opcode);
            check($sformatf("vec%0d_exec_seen", v), ok, 1);
            check($sformatf("vec%0d_exec_cycle", v), at, tbl[v].exp_cyc);
            check($sformatf("vec%0d_next_pc", v), bus.pm_addr, tbl[v].exp_pc);
            check($sformatf("vec%0d_opcode", v), bus.opcode, tbl[v].exp_op);
            check($sformatf("vec%0d_cond", v), bus.cond, tbl[v].b0[1:0]);
            check($sformatf("vec%0d_operand", v), bus.operand,
                  MASK[tbl[v].b0[7:4]] ? tbl[v].b1 : 8'h00);
            // Every target holds HALT: FETCH + DECODE, then halted.
            wait_halt(6, at, ok);
            check($sformatf("vec%0d_halt_cycle", v), at, tbl[v].exp_cyc + 2);
            check($sformatf("vec%0d_halt_pc", v), bus.pm_addr, tbl[v].exp_pc + 8'd1);
        end

        // ---------------- straight line ----------------
        fill_pm(8'hF0);
        pm[0] = 8'h10;
        pm[1] = 8'h20;
        pm[2] = 8'hF0;
        do_reset();
        halt_at = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.exec) begin
                q_cyc.push_back(cyc);
                q_op.push_back(int'(bus.opcode));
            end
            if (bus.halted && halt_at < 0) halt_at = cyc;
        end
        $display("straight: %0d exec pulses, halted at %0d, pm_addr %0d", q_cyc.size(), halt_at, bus.pm_addr);
        check("straight_exec_count", q_cyc.size(), 2);
        check("straight_exec0_cycle", q_cyc.size() > 0 ? q_cyc[0] : -1, 3);
        check("straight_exec1_cycle", q_cyc.size() > 1 ? q_cyc[1] : -1, 6);
        check("straight_exec0_op", q_op.size() > 0 ? q_op[0] : -1, 1);
        check("straight_exec1_op", q_op.size() > 1 ? q_op[1] : -1, 2);
        check("straight_halt_cycle", halt_at, 8);
        check("straight_pc_frozen", bus.pm_addr, 3);
        check("straight_exec_in_halt", bus.exec, 0);

        // ---------------- stalls ----------------
        stall_test("inbox_stall", 8'h40, 1'b1, 4);
        stall_test("outbox_stall", 8'h50, 1'b0, 4);
        stall_test("inbox_stall1", 8'h40, 1'b1, 1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;

        // ---------------- wraparound ----------------
        // 255 one-byte NOPs, then a two-byte instruction at 255 whose
        // operand byte comes from address 0 (the first NOP, 0x0C).
        fill_pm(8'h0C);
        pm[255] = 8'hB0;
        bus.alu_zero = 1'b0;
        bus.alu_neg  = 1'b0;
        do_reset();
        n_exec = 0;
        prev = 0;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (bus.exec) begin
                n_exec++;
                if (n_exec == 256) begin
                    ok = 1'b1;
                    break;
                end
                prev = cyc;
            end
        end
        $display("wrap: exec %0d, opcode %0h, operand %02h, pm_addr %0d", n_exec, bus.opcode, bus.operand, bus.pm_addr);
        check("wrap_reached", ok, 1);
        check("wrap_opcode", bus.opcode, 4'hB);
        check("wrap_operand", bus.operand, 8'h0C);
        check("wrap_pc", bus.pm_addr, 1);
        check("wrap_latency", cyc - prev, 5);

        // ---------------- async reset during OPWAIT ----------------
        fill_pm(8'hF0);
        pm[0] = 8'h80;
        pm[1] = 8'h05;
        do_reset();
        tick();
        tick();
        check("areset_pre_pc", bus.pm_addr, 1);
        check("areset_pre_op", bus.opcode, 4'h8);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset at t=%0t: pm_addr %0d opcode %0h exec %0d", $time, bus.pm_addr, bus.opcode, bus.exec);
        check("areset_pc", bus.pm_addr, 0);
        check("areset_opcode", bus.opcode, 0);
        check("areset_exec", bus.exec, 0);
        check("areset_halted", bus.halted, 0);
        @(posedge clk);
        #1;
        check("areset_hold_exec", bus.exec, 0);
        check("areset_hold_pc", bus.pm_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        wait_exec(20, at, ok);
        check("areset_refetch_cycle", at, 5);
        check("areset_refetch_pc", bus.pm_addr, 5);
        check("areset_refetch_operand", bus.operand, 8'h05);

        // ---------------- random programs vs instruction-level model ----------------
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                pm[i] = 8'($urandom_range(0, 255));
                if (pm[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) pm[i][7:4] = 4'h0;
            end
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            zero_m = 1'($urandom_range(0, 1));
            neg_m  = 1'($urandom_range(0, 1));
            bus.alu_zero = zero_m;
            bus.alu_neg  = neg_m;
            do_reset();
            pc_m = 8'd0;
            prev = 0;
            for (int k = 0; k < 40; k++) begin
                b_m  = pm[pc_m];
                op_m = b_m[7:4];
                if (op_m == 4'hF) begin
                    wait_halt(10, at, ok);
                    $display("rand %0d.%0d: pc %0d HALT, halted at +%0d", r, k, pc_m, at - prev);
                    check("rand_halt_seen", ok, 1);
                    check("rand_halt_latency", at - prev, 2);
                    check("rand_halt_pc", bus.pm_addr, pc_m + 8'd1);
                    break;
                end
                len_m  = MASK[op_m] ? 2 : 1;
                opnd_m = pm[pc_m + 8'd1];
                case (op_m)
                    4'h8, 4'hA: taken_m = 1'b1;
                    4'h9:       taken_m = (b_m[1:0] == 2'd0) ||
                                          (b_m[1:0] == 2'd1 && zero_m) ||
                                          (b_m[1:0] == 2'd2 && neg_m);
                    default:    taken_m = 1'b0;
                endcase
                next_m = taken_m ? opnd_m : pc_m + 8'(len_m);
                wait_exec(10, at, ok);
                $display("rand %0d.%0d: pc %0d instr %02h -> next %0d, exec +%0d",
                         r, k, pc_m, b_m, bus.pm_addr, at - prev);
                check("rand_exec_seen", ok, 1);
                check("rand_latency", at - prev, len_m == 2 ? 5 : 3);
                check("rand_opcode", bus.opcode, op_m);
                check("rand_cond", bus.cond, b_m[1:0]);
                check("rand_next_pc", bus.pm_addr, next_m);
                if (len_m == 2) check("rand_operand", bus.operand, opnd_m);
                if (!ok) break;
                prev = at;
                pc_m = next_m;
                zero_m = 1'($urandom_range(0, 1));
                neg_m  = 1'($urandom_range(0, 1));
                bus.alu_zero = zero_m;
                bus.alu_neg  = neg_m;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
